// File: rtl/serializer_12bit_if.sv
// Parallel word handshake into the serializer: valid/ready with a data word.
interface serializer_12bit_if #(
   parameter int unsigned WIDTH = 12
) ();

   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;

   // Word source side
   modport master (
      output in_data,
      output in_valid,
      input  in_ready
   );

   // Serializer side
   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready
   );

endinterface

// File: rtl/serializer_12bit.sv
// Word serializer: sends a training burst after reset, then user words or an
// idle fill word, MSB first, one word every WIDTH clocks with no gaps.
module serializer_12bit #(
   parameter int unsigned      WIDTH       = 12,
   parameter logic [WIDTH-1:0] TRAIN_WORD  = 12'hFC0,
   parameter int unsigned      TRAIN_COUNT = 16,
   parameter logic [WIDTH-1:0] IDLE_WORD   = 12'h555
) (
   input  logic                clk,
   input  logic                rst,
   serializer_12bit_if.slave   in_bus,
   output logic                serial_data,
   output logic                word_start,
   output logic                data_phase,
   output logic                training
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [0:0] {
      StTrain,
      StRun
   } state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  sh_q, sh_d;
   logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0]  hold_q, hold_d;
   logic              hold_valid_q, hold_valid_d;
   logic [7:0]        train_cnt_q, train_cnt_d;
   logic              serial_q, serial_d;
   logic              word_start_q, word_start_d;
   logic              data_phase_q, data_phase_d;

   logic              boundary;
   logic              sel_hold;
   logic              accept;
   logic [WIDTH-1:0]  next_word;
   logic [CntW-1:0]   bit_idx;

   // Ready depends only on the hold register; reset forces it low.
   assign in_bus.in_ready = !hold_valid_q && rst;
   assign training        = !rst || (state_q == StTrain);
   assign serial_data     = serial_q;
   assign word_start      = word_start_q;
   assign data_phase      = data_phase_q;

   // Next-state: word selection at boundaries, bit shifting otherwise, hold accept
   always_comb begin
      state_d      = state_q;
      sh_d         = sh_q;
      bit_cnt_d    = bit_cnt_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      train_cnt_d  = train_cnt_q;
      serial_d     = serial_q;
      word_start_d = word_start_q;
      data_phase_d = data_phase_q;

      boundary = (bit_cnt_q == CntW'(WIDTH - 1));
      sel_hold = (state_q == StRun) && hold_valid_q;
      accept   = in_bus.in_valid && in_bus.in_ready;
      bit_idx  = CntW'(WIDTH - 2) - bit_cnt_q;

      if (state_q == StTrain) begin
         next_word = TRAIN_WORD;
      end else if (hold_valid_q) begin
         next_word = hold_q;
      end else begin
         next_word = IDLE_WORD;
      end

      if (boundary) begin
         sh_d         = next_word;
         serial_d     = next_word[WIDTH-1];
         word_start_d = 1'b1;
         bit_cnt_d    = '0;
         data_phase_d = sel_hold;
         if (sel_hold) begin
            hold_valid_d = 1'b0;
         end
         if (state_q == StTrain) begin
            train_cnt_d = train_cnt_q + 8'd1;
            // The boundary emitting the last training word hands over to RUN.
            if (train_cnt_q == 8'(TRAIN_COUNT - 1)) begin
               state_d = StRun;
            end
         end
      end else begin
         bit_cnt_d    = bit_cnt_q + CntW'(1);
         serial_d     = sh_q[bit_idx];
         word_start_d = 1'b0;
      end

      // Ready is low while holding, so accept never collides with consume.
      if (accept) begin
         hold_d       = in_bus.in_data;
         hold_valid_d = 1'b1;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= StTrain;
         sh_q         <= '0;
         bit_cnt_q    <= CntW'(WIDTH - 1);
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         train_cnt_q  <= '0;
         serial_q     <= 1'b0;
         word_start_q <= 1'b0;
         data_phase_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sh_q         <= sh_d;
         bit_cnt_q    <= bit_cnt_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         train_cnt_q  <= train_cnt_d;
         serial_q     <= serial_d;
         word_start_q <= word_start_d;
         data_phase_q <= data_phase_d;
      end
   end

endmodule

// File: tb/tb_serializer_12bit.sv
// Bench for serializer_12bit: word-level reference model, scenario tasks.
module tb_serializer_12bit;

   localparam int unsigned W  = 12;
   localparam int unsigned TC = 16;
   localparam logic [W-1:0] TW = 12'hFC0;
   localparam logic [W-1:0] IW = 12'h555;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic serial_data, word_start, data_phase, training;

   serializer_12bit_if #(.WIDTH(W)) bus ();

   serializer_12bit #(
      .WIDTH       (W),
      .TRAIN_WORD  (TW),
      .TRAIN_COUNT (TC),
      .IDLE_WORD   (IW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_bus      (bus),
      .serial_data (serial_data),
      .word_start  (word_start),
      .data_phase  (data_phase),
      .training    (training)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: edges since reset release, current word, pending word.
   int          m_e = 0;
   int          m_acc = 0;
   logic [W-1:0] m_word = '0;
   logic        m_ser = 1'b0, m_ws = 1'b0, m_dp = 1'b0;
   logic        m_pend = 1'b0;
   logic [W-1:0] m_pend_word = '0;

   function automatic logic [4:0] exp_vec();
      logic tr;
      tr = !rst || (m_e <= int'((TC - 1) * W));
      return {m_ser, m_ws, m_dp, tr, rst && !m_pend};
   endfunction

   function automatic logic [4:0] act_vec();
      return {serial_data, word_start, data_phase, training, bus.in_ready};
   endfunction

   // One clock: advance the model on the rising edge, return at the falling edge.
   task automatic tick();
      bit acc;
      int k;
      @(posedge clk);
      if (!rst) begin
         m_e = 0; m_pend = 1'b0; m_ser = 1'b0; m_ws = 1'b0; m_dp = 1'b0;
      end else begin
         acc = bus.in_valid && !m_pend;
         k = m_e % W;
         if (k == 0) begin
            if (m_e / W < TC) begin
               m_word = TW; m_dp = 1'b0;
            end else if (m_pend) begin
               m_word = m_pend_word; m_dp = 1'b1; m_pend = 1'b0;
            end else begin
               m_word = IW; m_dp = 1'b0;
            end
            m_ws = 1'b1;
         end else begin
            m_ws = 1'b0;
         end
         m_ser = m_word[W-1-k];
         m_e++;
         if (acc) begin
            m_pend = 1'b1; m_pend_word = bus.in_data; m_acc++;
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      bus.in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if (act_vec() !== exp_vec() || act_vec() !== 5'b00010) begin
            n_fail++;
            $display("FAIL reset: got %b want %b", act_vec(), exp_vec());
         end
      end
      rst = 1'b1;
   endtask

   task automatic test_train_idle();
      for (int i = 0; i < int'(TC * W) + 36; i++) begin
         tick();
         n_tests++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL train_idle[%0d]: got %b want %b", i, act_vec(), exp_vec());
         end
      end
      n_tests++;
      if (training !== 1'b0) begin
         n_fail++;
         $display("FAIL train_done: got %b want 0", training);
      end
   endtask

   task automatic test_train_accept();
      do_reset();
      for (int i = 0; i < int'(TC * W) + 48; i++) begin
         bus.in_valid = (i == 30);
         bus.in_data  = 12'hA3C;
         tick();
         n_tests++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL train_accept[%0d]: got %b want %b", i, act_vec(), exp_vec());
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      int idx = 0;
      int dp_cnt = 0;
      int dp_rise = 0;
      int a0;
      logic dp_prev = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 12'h001;
      a0 = m_acc;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (m_acc - a0 > idx) begin
            idx = m_acc - a0;
            bus.in_data = W'(idx + 1);
            if (idx == 3) bus.in_valid = 1'b0;
         end
         if (data_phase === 1'b1) dp_cnt++;
         if (data_phase === 1'b1 && !dp_prev) dp_rise++;
         dp_prev = data_phase;
         n_tests++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL back_to_back[%0d]: got %b want %b", i, act_vec(), exp_vec());
         end
      end
      bus.in_valid = 1'b0;
      n_tests++;
      if (dp_cnt != 3 * W || dp_rise != 1) begin
         n_fail++;
         $display("FAIL b2b_contiguous: got %0d bits/%0d runs want %0d/1", dp_cnt, dp_rise, 3 * W);
      end
   endtask

   task automatic test_boundary_accept();
      int budget = 40;
      int cnt = 0;
      while (!(m_e % W == 0 && !m_pend) && budget > 0) begin
         tick();
         budget--;
      end
      n_tests++;
      if (budget == 0) begin
         n_fail++;
         $display("FAIL bnd_wait: got timeout want boundary");
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 12'hFFF;
      tick();
      bus.in_valid = 1'b0;
      n_tests++;
      if (act_vec() !== exp_vec() || serial_data !== IW[W-1]) begin
         n_fail++;
         $display("FAIL bnd_idle: got %b want %b", act_vec(), exp_vec());
      end
      // MSB lands W edges after the accepting edge, visible in cycle t+W+1.
      budget = 40;
      while (!(data_phase === 1'b1 && word_start === 1'b1) && budget > 0) begin
         tick();
         cnt++;
         budget--;
         n_tests++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL bnd_stream: got %b want %b", act_vec(), exp_vec());
         end
      end
      n_tests++;
      if (cnt != W) begin
         n_fail++;
         $display("FAIL bnd_latency: got %0d edges want %0d", cnt, W);
      end
   endtask

   task automatic test_hold_stable();
      for (int i = 0; i < 90; i++) begin
         bus.in_valid = (i < 60);
         bus.in_data  = W'($urandom);
         tick();
         n_tests++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL hold_stable[%0d]: got %b want %b", i, act_vec(), exp_vec());
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset_mid_word();
      int budget = 60;
      int a0 = m_acc;
      int dp_cnt = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = W'($urandom);
      while (m_acc - a0 < 2 && budget > 0) begin
         tick();
         if (m_acc - a0 == 1) bus.in_data = 12'h9B6;
         budget--;
      end
      bus.in_valid = 1'b0;
      budget = 20;
      while (m_e % W != 6 && budget > 0) begin
         tick();
         budget--;
      end
      n_tests++;
      if (budget == 0 || !m_pend || !m_dp) begin
         n_fail++;
         $display("FAIL rmw_setup: got pend=%b dp=%b want 1/1", m_pend, m_dp);
      end
      rst = 1'b0;
      tick();
      n_tests++;
      if (act_vec() !== exp_vec() || act_vec() !== 5'b00010) begin
         n_fail++;
         $display("FAIL rmw_reset: got %b want %b", act_vec(), exp_vec());
      end
      rst = 1'b1;
      for (int i = 0; i < int'(TC * W) + 36; i++) begin
         tick();
         if (data_phase === 1'b1) dp_cnt++;
         n_tests++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL rmw_retrain[%0d]: got %b want %b", i, act_vec(), exp_vec());
         end
      end
      n_tests++;
      if (dp_cnt != 0) begin
         n_fail++;
         $display("FAIL rmw_discard: got %0d data bits want 0", dp_cnt);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         bus.in_valid = ($urandom_range(0, 3) == 0);
         bus.in_data  = W'($urandom);
         tick();
         n_tests++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL random[%0d]: got %b want %b", i, act_vec(), exp_vec());
         end
      end
      bus.in_valid = 1'b0;
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      test_reset();
      test_train_idle();
      test_train_accept();
      test_back_to_back();
      test_boundary_accept();
      test_hold_stable();
      test_reset_mid_word();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
